// File: rtl/ad9648_pkg.sv
// ad9648_pkg: shared definitions for the AD9648 output-side emulator.
// Holds the pattern-select encodings, the power/run state type, the PN9
// generator seeds and taps, and the checkerboard source word.
package ad9648_pkg;

  // Pattern select encodings; codes 5..7 fall back to constant mode.
  localparam logic [2:0] MODE_CONST = 3'd0;
  localparam logic [2:0] MODE_RAMP  = 3'd1;
  localparam logic [2:0] MODE_CHECK = 3'd2;
  localparam logic [2:0] MODE_PN9   = 3'd3;
  localparam logic [2:0] MODE_FS    = 3'd4;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    RUN  = 2'd2
  } state_e;

  // PN9: x^9 + x^5 + 1, shift left, feedback = bit8 ^ bit4.
  localparam logic [8:0] PN9_SEED_A = 9'h1FF;
  localparam logic [8:0] PN9_SEED_B = 9'h0F0;
  localparam int         PN9_TAP_HI = 8;
  localparam int         PN9_TAP_LO = 4;

  // 1010... pattern; the top bit_width bits form the checkerboard word.
  localparam logic [31:0] CHECK_WORD = 32'hAAAA_AAAA;

  function automatic logic [8:0] pn9_next(input logic [8:0] s);
    return {s[7:0], s[PN9_TAP_HI] ^ s[PN9_TAP_LO]};
  endfunction

endpackage

// File: rtl/ad9648_emu_delay.sv
// ad9648_emu_delay: fixed-depth shift register carrying one packed sample
// word per clock. A synchronous flush (or reset) clears every stage at once,
// so nothing queued before a power-down can emerge afterwards.
// Ports:
//   i_clk    clock
//   i_rst_n  synchronous reset, active low
//   i_flush  synchronous clear of all stages
//   i_data   word entering stage 0
//   o_data   word leaving the last stage
module ad9648_emu_delay #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
    end else begin
      r_stage[0] <= i_data;
      for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/ad9648_emu.sv
// ad9648_emu: cycle-accurate stand-in for the AD9648 dual ADC output side.
// After the active-low enable is seen, a wake period elapses, then one A and
// one B test-pattern sample are generated per clock and delivered through a
// fixed-latency delay line together with per-channel overrange flags.
// Ports:
//   clk                  sample clock
//   reset_n              synchronous reset, active low
//   enable               active low; high = power-down (flushes outputs)
//   mode                 0 const, 1 ramp, 2 checkerboard, 3 PN9, 4 full-scale
//   const_a / const_b    constant-mode sample values
//   data_a_bus/_b_bus    offset-binary samples
//   overrange_a/_b       sample is 0 or all-ones, aligned with the data
//   data_valid           buses carry a generated sample
module ad9648_emu
  import ad9648_pkg::*;
#(
  parameter int bit_width    = 14,
  parameter int wake_cycles  = 16,
  parameter int pipe_latency = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [2:0]           mode,
  input  logic [bit_width-1:0] const_a,
  input  logic [bit_width-1:0] const_b,
  output logic [bit_width-1:0] data_a_bus,
  output logic [bit_width-1:0] data_b_bus,
  output logic                 overrange_a,
  output logic                 overrange_b,
  output logic                 data_valid
);

  localparam int WAKE_W = (wake_cycles > 1) ? $clog2(wake_cycles) : 1;
  localparam int DLY_W  = 3 + 2 * bit_width;
  localparam logic [bit_width-1:0] ALL_ONES = {bit_width{1'b1}};

  // {LFSR, LFSR[bit_width-10:0]}: the 9 LFSR bits sit at the top and the
  // low LFSR bits are repeated underneath to fill the word.
  function automatic logic [bit_width-1:0] pn9_sample(input logic [8:0] s);
    logic [bit_width-1:0] r;
    r = '0;
    for (int i = 0; i < bit_width; i++) begin
      if (bit_width >= 9 && i >= bit_width - 9) r[i] = s[i-(bit_width-9)];
      else if (i < 9)                            r[i] = s[i];
    end
    return r;
  endfunction

  state_e               r_state, w_next_state;
  logic [WAKE_W-1:0]    r_wake_cnt;
  logic                 w_load_seed, w_advance, w_flush;

  logic [bit_width-1:0] r_ramp;
  logic                 r_phase;
  logic [8:0]           r_pn_a, r_pn_b;

  logic [bit_width-1:0] w_check;
  logic [bit_width-1:0] w_a, w_b;
  logic                 w_or_a, w_or_b;
  logic [DLY_W-1:0]     w_dly_in, w_dly_out;

  // State register and wake counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= OFF;
      r_wake_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == OFF && !enable)
        r_wake_cnt <= WAKE_W'(wake_cycles - 1);
      else if (r_state == WAKE && r_wake_cnt != '0)
        r_wake_cnt <= r_wake_cnt - WAKE_W'(1);
    end
  end

  // Next state: power-down wins over every transition, including WAKE->RUN.
  always_comb begin
    w_next_state = r_state;
    if (enable) begin
      w_next_state = OFF;
    end else begin
      case (r_state)
        OFF:     w_next_state = WAKE;
        WAKE:    if (r_wake_cnt == '0) w_next_state = RUN;
        RUN:     w_next_state = RUN;
        default: w_next_state = OFF;
      endcase
    end
  end

  // Control outputs
  always_comb begin
    w_flush     = enable;
    w_load_seed = (r_state == WAKE) && (r_wake_cnt == '0) && !enable;
    w_advance   = (r_state == RUN) && !enable;
  end

  // Generators advance every RUN cycle whatever the mode, so switching mode
  // picks up each pattern at its free-running position.
  always_ff @(posedge clk) begin
    if (w_load_seed) begin
      r_ramp  <= '0;
      r_phase <= 1'b0;
      r_pn_a  <= PN9_SEED_A;
      r_pn_b  <= PN9_SEED_B;
    end else if (w_advance) begin
      r_ramp  <= r_ramp + bit_width'(1);
      r_phase <= ~r_phase;
      r_pn_a  <= pn9_next(r_pn_a);
      r_pn_b  <= pn9_next(r_pn_b);
    end
  end

  assign w_check = CHECK_WORD[31 -: bit_width];

  always_comb begin
    w_a = const_a;
    w_b = const_b;
    case (mode)
      MODE_RAMP: begin
        w_a = r_ramp;
        w_b = ~r_ramp;
      end
      MODE_CHECK: begin
        w_a = r_phase ? ~w_check : w_check;
        w_b = r_phase ? w_check : ~w_check;
      end
      MODE_PN9: begin
        w_a = pn9_sample(r_pn_a);
        w_b = pn9_sample(r_pn_b);
      end
      MODE_FS: begin
        w_a = r_phase ? '0 : ALL_ONES;
        w_b = r_phase ? ALL_ONES : '0;
      end
      default: ;
    endcase
  end

  assign w_or_a = (w_a == '0) || (w_a == ALL_ONES);
  assign w_or_b = (w_b == '0) || (w_b == ALL_ONES);

  // Outside RUN the delay line is fed zeros so idle outputs stay at 0.
  assign w_dly_in = w_advance ? {1'b1, w_or_a, w_or_b, w_a, w_b} : '0;

  // Delay line: sample generated in cycle n reaches the buses at n+pipe_latency
  ad9648_emu_delay #(
    .WIDTH (DLY_W),
    .DEPTH (pipe_latency)
  ) u_delay (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_flush (w_flush),
    .i_data  (w_dly_in),
    .o_data  (w_dly_out)
  );

  assign {data_valid, overrange_a, overrange_b, data_a_bus, data_b_bus} = w_dly_out;

endmodule
